// File: rtl/pipe_run_ctrl_if.sv
// Board-side and core-side signals of the run/step controller.
// master = the controller, slave = the switches/buttons and the CPU core around it.
interface pipe_run_ctrl_if;
  logic [2:0]  pro_reset;
  logic        run_mode;
  logic        step_btn;
  logic        halt_req;
  logic        cpu_en;
  logic        cpu_rst;
  logic [11:0] prog_base;
  logic        halted;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;

  modport master (
    input  pro_reset, run_mode, step_btn, halt_req,
    output cpu_en, cpu_rst, prog_base, halted, state, cycle_cnt
  );

  modport slave (
    output pro_reset, run_mode, step_btn, halt_req,
    input  cpu_en, cpu_rst, prog_base, halted, state, cycle_cnt
  );
endinterface

// File: rtl/pipe_run_ctrl.sv
// Run/step controller for the pipelined CPU core: clock-enable, pipeline flush,
// program select, free-run / debounced single-step and halt handling.
module pipe_run_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned FLUSH_CYCLES    = 5,
  parameter logic [11:0] PROG_STRIDE     = 12'h100
) (
  input  logic            clk,
  input  logic            RST,
  pipe_run_ctrl_if.master bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] FL_INIT = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    FLUSH      = 3'd0,
    RUN        = 3'd1,
    STEP_WAIT  = 3'd2,
    STEP_PULSE = 3'd3,
    HALTED     = 3'd4
  } state_e;

  logic [2:0]    pro_s1_q, pro_s2_q, pro_prev_q;
  logic          run_s1_q, run_s2_q;
  logic          step_s1_q, step_s2_q;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic          db_lvl_q, db_lvl_d;
  logic          step_evt_q, step_evt_d;
  logic          prog_change;

  state_e        st_q;
  logic [FW-1:0] fl_q;
  logic          cpu_en_q, cpu_rst_q, halted_q;
  logic [11:0]   prog_base_q;
  logic [31:0]   cycle_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pro_s1_q   <= '0;
      pro_s2_q   <= '0;
      pro_prev_q <= '0;
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      db_cnt_q   <= '0;
      db_lvl_q   <= 1'b0;
      step_evt_q <= 1'b0;
    end else begin
      pro_s1_q   <= bus.pro_reset;
      pro_s2_q   <= pro_s1_q;
      pro_prev_q <= pro_s2_q;
      run_s1_q   <= bus.run_mode;
      run_s2_q   <= run_s1_q;
      step_s1_q  <= bus.step_btn;
      step_s2_q  <= step_s1_q;
      db_cnt_q   <= db_cnt_d;
      db_lvl_q   <= db_lvl_d;
      step_evt_q <= step_evt_d;
    end
  end

  // Counter only advances while the synced button disagrees with the accepted level;
  // any return to agreement restarts the stability window.
  always_comb begin
    db_cnt_d   = '0;
    db_lvl_d   = db_lvl_q;
    step_evt_d = 1'b0;
    if (step_s2_q != db_lvl_q) begin
      if (db_cnt_q == DB_MAX) begin
        db_lvl_d   = step_s2_q;
        step_evt_d = step_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + DW'(1);
      end
    end
  end

  assign prog_change = (pro_s2_q != pro_prev_q);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      st_q        <= FLUSH;
      fl_q        <= FL_INIT;
      cpu_en_q    <= 1'b0;
      cpu_rst_q   <= 1'b1;
      halted_q    <= 1'b0;
      prog_base_q <= '0;
      cycle_q     <= '0;
    end else begin
      if (cpu_en_q && (cycle_q != '1)) cycle_q <= cycle_q + 32'd1;

      // Program change overrides every state transition, including halt and step.
      if (prog_change) begin
        st_q        <= FLUSH;
        fl_q        <= FL_INIT;
        cycle_q     <= '0;
        halted_q    <= 1'b0;
        cpu_en_q    <= 1'b0;
        cpu_rst_q   <= 1'b1;
        prog_base_q <= 12'({9'd0, pro_s2_q} * PROG_STRIDE);
      end else begin
        case (st_q)
          FLUSH: begin
            cpu_en_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
            if (fl_q == '0) begin
              cpu_rst_q <= 1'b0;
              if (run_s2_q) begin
                st_q     <= RUN;
                cpu_en_q <= 1'b1;
              end else begin
                st_q <= STEP_WAIT;
              end
            end else begin
              fl_q <= fl_q - FW'(1);
            end
          end
          RUN: begin
            if (bus.halt_req) begin
              st_q     <= HALTED;
              cpu_en_q <= 1'b0;
              halted_q <= 1'b1;
            end else if (!run_s2_q) begin
              st_q     <= STEP_WAIT;
              cpu_en_q <= 1'b0;
            end else begin
              cpu_en_q <= 1'b1;
            end
          end
          STEP_WAIT: begin
            if (run_s2_q) begin
              st_q     <= RUN;
              cpu_en_q <= 1'b1;
            end else if (step_evt_q) begin
              st_q     <= STEP_PULSE;
              cpu_en_q <= 1'b1;
            end else begin
              cpu_en_q <= 1'b0;
            end
          end
          STEP_PULSE: begin
            if (bus.halt_req) begin
              st_q     <= HALTED;
              cpu_en_q <= 1'b0;
              halted_q <= 1'b1;
            end else if (run_s2_q) begin
              st_q     <= RUN;
              cpu_en_q <= 1'b1;
            end else begin
              st_q     <= STEP_WAIT;
              cpu_en_q <= 1'b0;
            end
          end
          HALTED: begin
            cpu_en_q <= 1'b0;
            halted_q <= 1'b1;
          end
          default: begin
            st_q      <= FLUSH;
            fl_q      <= FL_INIT;
            cpu_en_q  <= 1'b0;
            cpu_rst_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.cpu_en    = cpu_en_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.prog_base = prog_base_q;
  assign bus.halted    = halted_q;
  assign bus.state     = st_q;
  assign bus.cycle_cnt = cycle_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl: reset/run, program change, bounced step,
// halt, halt during a step, coincident events and asynchronous reset.
module tb_pipe_run_ctrl;
  logic clk = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  pipe_run_ctrl_if ctl_if ();

  pipe_run_ctrl #(
    .DEBOUNCE_CYCLES(16),
    .FLUSH_CYCLES   (5),
    .PROG_STRIDE    (12'h100)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(ctl_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int cnt, n;
    RST = 1'b1;
    ctl_if.pro_reset = 3'd0;
    ctl_if.run_mode  = 1'b1;
    ctl_if.step_btn  = 1'b0;
    ctl_if.halt_req  = 1'b0;
    #1;
    checks++; if (ctl_if.cpu_en !== 1'b0) begin errors++; $display("FAIL rst_cpu_en got %0b exp 0", ctl_if.cpu_en); end
    checks++; if (ctl_if.cpu_rst !== 1'b1) begin errors++; $display("FAIL rst_cpu_rst got %0b exp 1", ctl_if.cpu_rst); end
    checks++; if (ctl_if.state !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", ctl_if.state); end
    checks++; if (ctl_if.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b exp 0", ctl_if.halted); end
    checks++; if (ctl_if.prog_base !== 12'h000) begin errors++; $display("FAIL rst_prog_base got %h exp 000", ctl_if.prog_base); end
    checks++; if (ctl_if.cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_cycle_cnt got %0d exp 0", ctl_if.cycle_cnt); end
    #19;
    RST = 1'b0;
    #1;
    cnt = 0;
    n = 0;
    while (ctl_if.cpu_en !== 1'b1 && n < 20) begin
      if (ctl_if.cpu_rst === 1'b1) cnt++;
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.cpu_en !== 1'b1) begin errors++; $display("FAIL rst_run_start got cpu_en=%0b exp 1 (timeout)", ctl_if.cpu_en); end
    checks++; if (cnt != 5) begin errors++; $display("FAIL rst_flush_len got %0d exp 5", cnt); end
  endtask

  task automatic test_run();
    int en = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) en++;
    end
    checks++; if (en != 10) begin errors++; $display("FAIL run_enabled got %0d exp 10", en); end
    checks++; if (ctl_if.cycle_cnt !== 32'd10) begin errors++; $display("FAIL run_cycle_cnt got %0d exp 10", ctl_if.cycle_cnt); end
    checks++; if (ctl_if.state !== 3'd1) begin errors++; $display("FAIL run_state got %0d exp 1", ctl_if.state); end
  endtask

  task automatic test_prog_change();
    int n, cnt;
    ctl_if.pro_reset = 3'd3;
    n = 0;
    while (ctl_if.state !== 3'd0 && n < 3) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.state !== 3'd0 || n != 3) begin errors++; $display("FAIL pc_latency got state=%0d after %0d cycles exp state=0 after 3", ctl_if.state, n); end
    checks++; if (ctl_if.prog_base !== 12'h300) begin errors++; $display("FAIL pc_prog_base got %h exp 300", ctl_if.prog_base); end
    checks++; if (ctl_if.cycle_cnt !== 32'd0) begin errors++; $display("FAIL pc_cycle_cnt got %0d exp 0", ctl_if.cycle_cnt); end
    cnt = 0;
    n = 0;
    while (ctl_if.cpu_en !== 1'b1 && n < 20) begin
      if (ctl_if.cpu_rst === 1'b1) cnt++;
      @(negedge clk);
      n++;
    end
    checks++; if (cnt != 5) begin errors++; $display("FAIL pc_flush_len got %0d exp 5", cnt); end
    checks++; if (ctl_if.state !== 3'd1) begin errors++; $display("FAIL pc_resume got state=%0d exp 1", ctl_if.state); end
  endtask

  task automatic test_step_bounce();
    int pulses = 0;
    logic [31:0] c0;
    ctl_if.run_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ctl_if.state !== 3'd2 || ctl_if.cpu_en !== 1'b0) begin errors++; $display("FAIL step_wait got state=%0d en=%0b exp state=2 en=0", ctl_if.state, ctl_if.cpu_en); end
    c0 = ctl_if.cycle_cnt;
    for (int i = 0; i < 30; i++) begin
      ctl_if.step_btn = (((i / 3) % 2) == 0);
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) pulses++;
    end
    ctl_if.step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) pulses++;
    end
    ctl_if.step_btn = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) pulses++;
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulses got %0d exp 1", pulses); end
    checks++; if (ctl_if.cycle_cnt !== c0 + 32'd1) begin errors++; $display("FAIL step_cycle_cnt got %0d exp %0d", ctl_if.cycle_cnt, c0 + 32'd1); end
    checks++; if (ctl_if.state !== 3'd2) begin errors++; $display("FAIL step_back_wait got %0d exp 2", ctl_if.state); end
  endtask

  task automatic test_halt();
    int pulses = 0;
    int n;
    logic [31:0] ch;
    ctl_if.run_mode = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ctl_if.state !== 3'd1 || ctl_if.cpu_en !== 1'b1) begin errors++; $display("FAIL halt_pre_run got state=%0d en=%0b exp state=1 en=1", ctl_if.state, ctl_if.cpu_en); end
    ch = ctl_if.cycle_cnt;
    ctl_if.halt_req = 1'b1;
    @(negedge clk);
    ctl_if.halt_req = 1'b0;
    checks++; if (ctl_if.halted !== 1'b1 || ctl_if.cpu_en !== 1'b0 || ctl_if.state !== 3'd4) begin errors++; $display("FAIL halt_enter got halted=%0b en=%0b state=%0d exp 1 0 4", ctl_if.halted, ctl_if.cpu_en, ctl_if.state); end
    checks++; if (ctl_if.cycle_cnt !== ch + 32'd1) begin errors++; $display("FAIL halt_cycle_counted got %0d exp %0d", ctl_if.cycle_cnt, ch + 32'd1); end
    ctl_if.step_btn = 1'b1;
    for (int i = 0; i < 55; i++) begin
      if (i == 5)  ctl_if.run_mode = 1'b0;
      if (i == 15) ctl_if.run_mode = 1'b1;
      if (i == 30) ctl_if.step_btn = 1'b0;
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL halt_ignore got %0d enabled cycles exp 0", pulses); end
    checks++; if (ctl_if.state !== 3'd4 || ctl_if.cycle_cnt !== ch + 32'd1) begin errors++; $display("FAIL halt_hold got state=%0d cnt=%0d exp 4 %0d", ctl_if.state, ctl_if.cycle_cnt, ch + 32'd1); end
    ctl_if.pro_reset = 3'd5;
    n = 0;
    while (ctl_if.state !== 3'd0 && n < 3) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.state !== 3'd0 || ctl_if.halted !== 1'b0) begin errors++; $display("FAIL halt_exit got state=%0d halted=%0b exp 0 0", ctl_if.state, ctl_if.halted); end
    checks++; if (ctl_if.prog_base !== 12'h500) begin errors++; $display("FAIL halt_exit_base got %h exp 500", ctl_if.prog_base); end
    n = 0;
    while (ctl_if.cpu_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.state !== 3'd1) begin errors++; $display("FAIL halt_rerun got state=%0d exp 1", ctl_if.state); end
  endtask

  task automatic test_halt_step();
    int n = 0;
    int pulses = 0;
    ctl_if.run_mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ctl_if.state !== 3'd2) begin errors++; $display("FAIL hs_wait got %0d exp 2", ctl_if.state); end
    ctl_if.step_btn = 1'b1;
    while (ctl_if.state !== 3'd3 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.state !== 3'd3 || ctl_if.cpu_en !== 1'b1) begin errors++; $display("FAIL hs_pulse got state=%0d en=%0b exp 3 1", ctl_if.state, ctl_if.cpu_en); end
    ctl_if.halt_req = 1'b1;
    @(negedge clk);
    ctl_if.halt_req = 1'b0;
    checks++; if (ctl_if.state !== 3'd4 || ctl_if.cpu_en !== 1'b0 || ctl_if.halted !== 1'b1) begin errors++; $display("FAIL hs_halt got state=%0d en=%0b halted=%0b exp 4 0 1", ctl_if.state, ctl_if.cpu_en, ctl_if.halted); end
    ctl_if.step_btn = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ctl_if.cpu_en === 1'b1) pulses++;
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL hs_stay got %0d enabled cycles exp 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    ctl_if.run_mode  = 1'b1;
    ctl_if.pro_reset = 3'd1;
    while (!(ctl_if.state === 3'd1 && ctl_if.cpu_en === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.state !== 3'd1 || ctl_if.prog_base !== 12'h100) begin errors++; $display("FAIL b2b_run got state=%0d base=%h exp 1 100", ctl_if.state, ctl_if.prog_base); end
    ctl_if.pro_reset = 3'd2;
    repeat (2) @(negedge clk);
    checks++; if (ctl_if.state !== 3'd1) begin errors++; $display("FAIL b2b_pre got state=%0d exp 1", ctl_if.state); end
    ctl_if.halt_req = 1'b1;
    @(negedge clk);
    ctl_if.halt_req = 1'b0;
    checks++; if (ctl_if.state !== 3'd0 || ctl_if.halted !== 1'b0 || ctl_if.cpu_rst !== 1'b1) begin errors++; $display("FAIL b2b_flush_wins got state=%0d halted=%0b rst=%0b exp 0 0 1", ctl_if.state, ctl_if.halted, ctl_if.cpu_rst); end
    checks++; if (ctl_if.prog_base !== 12'h200) begin errors++; $display("FAIL b2b_base got %h exp 200", ctl_if.prog_base); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    while (ctl_if.cpu_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++; if (ctl_if.cpu_en !== 1'b1) begin errors++; $display("FAIL ar_pre got cpu_en=%0b exp 1", ctl_if.cpu_en); end
    #2;
    RST = 1'b1;
    #1;
    checks++; if (ctl_if.cpu_en !== 1'b0 || ctl_if.cpu_rst !== 1'b1 || ctl_if.state !== 3'd0) begin errors++; $display("FAIL ar_async got en=%0b rst=%0b state=%0d exp 0 1 0", ctl_if.cpu_en, ctl_if.cpu_rst, ctl_if.state); end
    checks++; if (ctl_if.prog_base !== 12'h000 || ctl_if.cycle_cnt !== 32'd0) begin errors++; $display("FAIL ar_clear got base=%h cnt=%0d exp 000 0", ctl_if.prog_base, ctl_if.cycle_cnt); end
    @(negedge clk);
    RST = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ctl_if.prog_base !== 12'h000) begin errors++; $display("FAIL ar_base_early got %h exp 000", ctl_if.prog_base); end
    @(negedge clk);
    checks++; if (ctl_if.prog_base !== 12'h200 || ctl_if.state !== 3'd0) begin errors++; $display("FAIL ar_prog_change got base=%h state=%0d exp 200 0", ctl_if.prog_base, ctl_if.state); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_prog_change();
    test_step_bounce();
    test_halt();
    test_halt_step();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
